// File: rtl/elevator_pkg.sv
// Shared state encoding and default timing for the elevator car sequencer.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    localparam int DEF_NUM_FLOORS    = 12;
    localparam int DEF_FLOOR_W       = 4;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES   = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational scan of outstanding calls relative to a floor: here / above / below.
module elevator_req_scan #(
    parameter int NUM_FLOORS = 12,
    parameter int FLOOR_W    = 4
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  here,
    output logic                  above,
    output logic                  below
);

    // Classify every pending call against the reference floor.
    always_comb begin
        here  = 1'b0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (i > int'(floor)) begin
                    above = 1'b1;
                end else if (i < int'(floor)) begin
                    below = 1'b1;
                end else begin
                    here = 1'b1;
                end
            end else begin
                here = here;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car SCAN sequencer: latches calls, steps one floor per travel period,
// and holds the door open at each served floor.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open,
    output logic                  moving,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TC_W = cnt_width(TRAVEL_CYCLES);
    localparam int DC_W = cnt_width(DOOR_CYCLES);
    localparam logic [TC_W-1:0]    TC_LAST   = TC_W'(TRAVEL_CYCLES - 1);
    localparam logic [DC_W-1:0]    DC_LAST   = DC_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    state_t                  state_r, state_n;
    logic [FLOOR_W-1:0]      floor_r, floor_n;
    logic [TC_W-1:0]         tcnt_r, tcnt_n;
    logic [DC_W-1:0]         dcnt_r, dcnt_n;
    logic                    dir_r, dir_n;
    logic                    door_r, moving_r;
    logic [NUM_FLOORS-1:0]   pending_r, clr_s;
    logic                    arrive_s, here_s, above_s, below_s;

    // The scan looks at the floor the car will occupy after this edge, so an
    // arrival can decide stop/continue in the same cycle the floor changes.
    elevator_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending (pending_r),
        .floor   (floor_n),
        .here    (here_s),
        .above   (above_s),
        .below   (below_s)
    );

    // Next floor: changes only at the end of a travel period, saturating at the ends.
    always_comb begin
        floor_n  = floor_r;
        arrive_s = 1'b0;
        case (state_r)
            ST_MOVE_UP: begin
                if (tcnt_r == TC_LAST) begin
                    arrive_s = 1'b1;
                    if (floor_r != TOP_FLOOR) floor_n = floor_r + FLOOR_W'(1);
                    else                      floor_n = floor_r;
                end else begin
                    arrive_s = 1'b0;
                end
            end
            ST_MOVE_DOWN: begin
                if (tcnt_r == TC_LAST) begin
                    arrive_s = 1'b1;
                    if (floor_r != {FLOOR_W{1'b0}}) floor_n = floor_r - FLOOR_W'(1);
                    else                            floor_n = floor_r;
                end else begin
                    arrive_s = 1'b0;
                end
            end
            default: floor_n = floor_r;
        endcase
    end

    // SCAN next-state, direction and timer control.
    always_comb begin
        state_n = state_r;
        dir_n   = dir_r;
        tcnt_n  = tcnt_r;
        dcnt_n  = dcnt_r;
        case (state_r)
            ST_IDLE: begin
                tcnt_n = {TC_W{1'b0}};
                dcnt_n = {DC_W{1'b0}};
                if (here_s) begin
                    state_n = ST_DOOR_OPEN;
                end else if (above_s && (dir_r || !below_s)) begin
                    state_n = ST_MOVE_UP;
                    dir_n   = 1'b1;
                end else if (below_s) begin
                    state_n = ST_MOVE_DOWN;
                    dir_n   = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (arrive_s) begin
                    tcnt_n = {TC_W{1'b0}};
                    dcnt_n = {DC_W{1'b0}};
                    if (here_s) begin
                        state_n = ST_DOOR_OPEN;
                    end else if ((state_r == ST_MOVE_UP) ? above_s : below_s) begin
                        state_n = state_r;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    tcnt_n = tcnt_r + TC_W'(1);
                end
            end
            ST_DOOR_OPEN: begin
                if (door_hold) begin
                    dcnt_n = {DC_W{1'b0}};
                end else if (dcnt_r == DC_LAST) begin
                    dcnt_n  = {DC_W{1'b0}};
                    state_n = ST_IDLE;
                end else begin
                    dcnt_n = dcnt_r + DC_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // A call for the floor the door is open at is served by that opening.
    always_comb begin
        if ((state_n == ST_DOOR_OPEN) || (state_r == ST_DOOR_OPEN)) clr_s = floor_onehot(floor_n);
        else                                                        clr_s = {NUM_FLOORS{1'b0}};
    end

    // State, counters, call register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            floor_r   <= {FLOOR_W{1'b0}};
            tcnt_r    <= {TC_W{1'b0}};
            dcnt_r    <= {DC_W{1'b0}};
            dir_r     <= 1'b1;
            door_r    <= 1'b0;
            moving_r  <= 1'b0;
            pending_r <= {NUM_FLOORS{1'b0}};
        end else begin
            state_r   <= state_n;
            floor_r   <= floor_n;
            tcnt_r    <= tcnt_n;
            dcnt_r    <= dcnt_n;
            dir_r     <= dir_n;
            door_r    <= (state_n == ST_DOOR_OPEN);
            moving_r  <= (state_n == ST_MOVE_UP) || (state_n == ST_MOVE_DOWN);
            pending_r <= (pending_r | req) & ~clr_s;
        end
    end

    assign current_floor = floor_r;
    assign door_open     = door_r;
    assign moving        = moving_r;
    assign dir_up        = dir_r;
    assign pending       = pending_r;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler: vector table plus SCAN sequences.
module tb_elevator_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] req;
    logic        door_hold;
    logic [3:0]  current_floor;
    logic        door_open;
    logic        moving;
    logic        dir_up;
    logic [11:0] pending;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    elevator_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .door_hold     (door_hold),
        .current_floor (current_floor),
        .door_open     (door_open),
        .moving        (moving),
        .dir_up        (dir_up),
        .pending       (pending)
    );

    typedef struct {
        logic        rst;
        logic [11:0] req;
        logic        hold;
        logic [3:0]  floor;
        logic        door;
        logic        mov;
        logic        dir;
        logic [11:0] pend;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [11:0] rq, input logic h);
        @(negedge clk);
        rst       = r;
        req       = rq;
        door_hold = h;
        @(posedge clk);
        #1;
        chk("door_and_moving", {31'd0, door_open & moving}, 32'd0);
    endtask

    initial begin
        int n;
        logic inj;
        logic [11:0] rq;
        rst = 1'b1; req = 12'h000; door_hold = 1'b0;

        // Tests 1 and 4: call at floor 0, door timing, door_hold extension, absorbed call.
        tbl[0]  = '{1'b1, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[1]  = '{1'b0, 12'h001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h001};
        tbl[2]  = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[3]  = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[4]  = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[5]  = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[7]  = '{1'b0, 12'h001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h001};
        tbl[8]  = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[9]  = '{1'b0, 12'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[10] = '{1'b0, 12'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[11] = '{1'b0, 12'h001, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[12] = '{1'b0, 12'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[13] = '{1'b0, 12'h000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[14] = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[15] = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 12'h000};
        tbl[16] = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[17] = '{1'b0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].hold);
            chk($sformatf("vec%0d_floor", i), {28'd0, current_floor}, {28'd0, tbl[i].floor});
            chk($sformatf("vec%0d_door", i), {31'd0, door_open}, {31'd0, tbl[i].door});
            chk($sformatf("vec%0d_moving", i), {31'd0, moving}, {31'd0, tbl[i].mov});
            chk($sformatf("vec%0d_dir", i), {31'd0, dir_up}, {31'd0, tbl[i].dir});
            chk($sformatf("vec%0d_pending", i), {20'd0, pending}, {20'd0, tbl[i].pend});
        end

        // Test 2: call floor 3 from floor 0, one floor every 4 clocks.
        step(1'b0, 12'h008, 1'b0);
        chk("t2_pend", {20'd0, pending}, 32'h008);
        chk("t2_idle", {31'd0, moving}, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 12'h000, 1'b0);
            chk($sformatf("t2_mov_e%0d", k), {31'd0, moving}, 32'd1);
            chk($sformatf("t2_floor_e%0d", k), {28'd0, current_floor}, (k - 1) / 4);
        end
        step(1'b0, 12'h000, 1'b0);
        chk("t2_arrive_floor", {28'd0, current_floor}, 32'd3);
        chk("t2_arrive_door", {31'd0, door_open}, 32'd1);
        chk("t2_arrive_pend", {20'd0, pending}, 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 12'h000, 1'b0);
        chk("t2_door_closed", {31'd0, door_open}, 32'd0);

        // Test 3: from 3 up to 8, floor-2 call injected while passing 5 upward.
        step(1'b0, 12'h100, 1'b0);
        n = 0; inj = 1'b0;
        while (!door_open && n < 40) begin
            rq = 12'h000;
            if (current_floor == 4'd5 && moving && !inj) begin
                rq  = 12'h004;
                inj = 1'b1;
                chk("t3_dir_at5", {31'd0, dir_up}, 32'd1);
            end else begin
                rq = 12'h000;
            end
            step(1'b0, rq, 1'b0);
            n++;
        end
        chk("t3_first_edges", n, 32'd21);
        chk("t3_first_floor", {28'd0, current_floor}, 32'd8);
        chk("t3_first_dir", {31'd0, dir_up}, 32'd1);
        chk("t3_first_pend", {20'd0, pending}, 32'h004);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 12'h000, 1'b0);
            n++;
        end
        chk("t3_door_closed", {31'd0, door_open}, 32'd0);
        while (!door_open && n < 90) begin
            step(1'b0, 12'h000, 1'b0);
            n++;
        end
        chk("t3_second_edges", n, 32'd49);
        chk("t3_second_floor", {28'd0, current_floor}, 32'd2);
        chk("t3_second_dir", {31'd0, dir_up}, 32'd0);
        chk("t3_second_pend", {20'd0, pending}, 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 12'h000, 1'b0);

        // Test 5: reset while moving up through floor 4 toward 9.
        step(1'b0, 12'h200, 1'b0);
        n = 0;
        while (!(current_floor == 4'd4 && moving) && n < 30) begin
            step(1'b0, 12'h000, 1'b0);
            n++;
        end
        chk("t5_at4_moving", {31'd0, moving}, 32'd1);
        chk("t5_at4_pend", {20'd0, pending}, 32'h200);
        step(1'b1, 12'h000, 1'b0);
        chk("t5_rst_floor", {28'd0, current_floor}, 32'd0);
        chk("t5_rst_pend", {20'd0, pending}, 32'd0);
        chk("t5_rst_moving", {31'd0, moving}, 32'd0);
        chk("t5_rst_dir", {31'd0, dir_up}, 32'd1);
        step(1'b0, 12'h000, 1'b0);
        chk("t5_idle_moving", {31'd0, moving}, 32'd0);
        chk("t5_idle_floor", {28'd0, current_floor}, 32'd0);

        // Test 6: simultaneous calls for 0 and 11; door at 0 first, then top floor, no overrun.
        step(1'b0, 12'h801, 1'b0);
        chk("t6_pend", {20'd0, pending}, 32'h801);
        step(1'b0, 12'h000, 1'b0);
        n = 1;
        chk("t6_door0", {31'd0, door_open}, 32'd1);
        chk("t6_door0_floor", {28'd0, current_floor}, 32'd0);
        chk("t6_door0_pend", {20'd0, pending}, 32'h800);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 12'h000, 1'b0);
            n++;
        end
        chk("t6_door0_closed", {31'd0, door_open}, 32'd0);
        while (!door_open && n < 90) begin
            step(1'b0, 12'h000, 1'b0);
            n++;
        end
        chk("t6_top_edges", n, 32'd49);
        chk("t6_top_floor", {28'd0, current_floor}, 32'd11);
        chk("t6_top_pend", {20'd0, pending}, 32'd0);
        for (int k = 0; k < 8; k++) step(1'b0, 12'h000, 1'b0);
        chk("t6_stay_floor", {28'd0, current_floor}, 32'd11);
        chk("t6_stay_moving", {31'd0, moving}, 32'd0);
        chk("t6_stay_door", {31'd0, door_open}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
